// File: rtl/mash_pkg.sv
// Shared constants and the dither LFSR step for the MASH 1-1 modulator.
package mash_pkg;

    localparam int MASH_Y_MIN = -1;
    localparam int MASH_Y_MAX = 2;

    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] MASH_LFSR_SEED = 16'hACE1;

    // Fibonacci form: shift left, feedback is the parity of the tapped bits (16,14,13,11).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// Wrapping accumulator with carry-in; the {carry, sum} outputs are this cycle's add result.
// Zero latency on {carry, sum}; the accumulator only advances while en is high.
module mash_acc_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cin,
    input  logic [WIDTH-1:0] addend,
    output logic             carry,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   total;

    always_comb begin
        total = {1'b0, acc_q} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
        acc_d = en ? total[WIDTH-1:0] : acc_q;
    end

    assign carry = total[WIDTH];
    assign sum   = total[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mash_11_modulator.sv
// MASH 1-1 delta-sigma stage: offset-binary sample in, signed y in {-1..2} out, one per cycle.
// Latency 1 cycle (registered output); s_tready drops only while the output register is stalled.
module mash_11_modulator
    import mash_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          MASH_BW   = 4,
    parameter logic [15:0] LFSR_SEED = MASH_LFSR_SEED
) (
    input  logic               aclk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               dither_enable,
    output logic [MASH_BW-1:0] m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready
);

    logic               accept;
    logic               dither_bit;
    logic               s1_carry;
    logic [WIDTH-1:0]   s1_sum;
    logic               s2_carry;
    logic [WIDTH-1:0]   s2_sum;
    logic [MASH_BW-1:0] y;

    logic               c2d_q, c2d_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [MASH_BW-1:0] m_tdata_q, m_tdata_d;
    logic               m_tvalid_q, m_tvalid_d;

    assign s_tready   = !rst && (!m_tvalid_q || m_tready);
    assign accept     = s_tvalid && s_tready;
    assign dither_bit = dither_enable & lfsr_q[0];

    mash_acc_stage #(.WIDTH(WIDTH)) u_stage1 (
        .clk    (aclk),
        .rst    (rst),
        .en     (accept),
        .cin    (dither_bit),
        .addend (s_tdata),
        .carry  (s1_carry),
        .sum    (s1_sum)
    );

    // Stage 2 integrates stage 1's fresh sum, not its registered value.
    mash_acc_stage #(.WIDTH(WIDTH)) u_stage2 (
        .clk    (aclk),
        .rst    (rst),
        .en     (accept),
        .cin    (1'b0),
        .addend (s1_sum),
        .carry  (s2_carry),
        .sum    (s2_sum)
    );

    always_comb begin
        // Modular MASH_BW-bit arithmetic yields the two's-complement y directly.
        y = {{(MASH_BW-1){1'b0}}, s1_carry}
          + {{(MASH_BW-1){1'b0}}, s2_carry}
          - {{(MASH_BW-1){1'b0}}, c2d_q};

        c2d_d      = c2d_q;
        lfsr_d     = lfsr_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;

        if (accept) begin
            c2d_d      = s2_carry;
            lfsr_d     = lfsr16_next(lfsr_q);
            m_tdata_d  = y;
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            c2d_q      <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            c2d_q      <= c2d_d;
            lfsr_q     <= lfsr_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_mash_11_modulator.sv
// Self-checking bench for mash_11_modulator: vector table, arithmetic reference model, handshake sequences.
module tb_mash_11_modulator;
    import mash_pkg::*;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        dither_enable = 1'b0;
    logic [3:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;

    mash_11_modulator #(.WIDTH(16), .MASH_BW(4), .LFSR_SEED(16'hACE1)) dut (
        .aclk          (aclk),
        .rst           (rst),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .dither_enable (dither_enable),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] x;
        bit          dith;
        int          exp_y;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, fractions as multiples of 2^-16.
    int          macc1, macc2, mc2d;
    logic [15:0] mlfsr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        macc1 = 0;
        macc2 = 0;
        mc2d  = 0;
        mlfsr = 16'hACE1;
    endtask

    task automatic model_step(input int x, input bit dith, output int y);
        int d, s1, s2, c1, c2;
        d     = dith ? int'(mlfsr[0]) : 0;
        s1    = macc1 + x + d;
        c1    = s1 / 65536;
        macc1 = s1 % 65536;
        s2    = macc2 + macc1;
        c2    = s2 / 65536;
        macc2 = s2 % 65536;
        y     = c1 + c2 - mc2d;
        mc2d  = c2;
        // x^16+x^14+x^13+x^11+1: feedback from stages 16,14,13,11
        mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    endtask

    function automatic int pat(input int k);
        return (k % 4 == 1 || k % 4 == 2) ? 1 : 0;
    endfunction

    task automatic do_reset();
        @(negedge aclk);
        rst           = 1'b1;
        s_tvalid      = 1'b0;
        m_tready      = 1'b1;
        dither_enable = 1'b0;
        #1;
        check("rst_s_tready", int'(s_tready), 0);
        check("rst_m_tvalid", int'(m_tvalid), 0);
        check("rst_m_tdata", int'(m_tdata), 0);
        @(posedge aclk);
        @(negedge aclk);
        rst = 1'b0;
        #1;
        check("post_rst_s_tready", int'(s_tready), 1);
        check("post_rst_m_tvalid", int'(m_tvalid), 0);
        model_reset();
    endtask

    task automatic send(input logic [15:0] x, input bit dith, output int y);
        @(negedge aclk);
        s_tdata       = x;
        dither_enable = dith;
        s_tvalid      = 1'b1;
        m_tready      = 1'b1;
        @(posedge aclk);
        #1;
        y = int'($signed(m_tdata));
        check("stream_m_tvalid", int'(m_tvalid), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   y, e, k, cyc, sum, bad_rng, bad_mdl;
        logic pv, pr, stall, took;
        logic [3:0] pd;
        logic [15:0] xr;
        bit   dr;

        for (int i = 0; i < 8; i++) begin
            tbl[i].x     = 16'h8000;
            tbl[i].dith  = 1'b0;
            tbl[i].exp_y = pat(i);
        end
        tbl[8]  = '{16'hC000, 1'b0, 0};
        tbl[9]  = '{16'hC000, 1'b0, 2};
        tbl[10] = '{16'hC000, 1'b0, 0};
        tbl[11] = '{16'hC000, 1'b0, 1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].x, tbl[i].dith, y);
            check($sformatf("tbl[%0d]", i), y, tbl[i].exp_y);
        end

        do_reset();
        for (int i = 0; i < 64; i++) begin
            send(16'h0000, 1'b0, y);
            check("zero_in", y, 0);
        end

        do_reset();
        for (int i = 0; i < 64; i++) begin
            send(16'h8000, 1'b0, y);
            check("half_pattern", y, pat(i));
        end

        do_reset();
        for (int i = 0; i < 200; i++) begin
            send(16'h0000, 1'b1, y);
            model_step(0, 1'b1, e);
            check("dither_model", y, e);
            check("dither_range", int'(y >= MASH_Y_MIN && y <= MASH_Y_MAX), 1);
        end
        do_reset();
        for (int i = 0; i < 200; i++) begin
            send(16'h0000, 1'b0, y);
            check("dither_off_zero", y, 0);
        end

        do_reset();
        for (int i = 0; i < 300; i++) begin
            xr = 16'($urandom_range(0, 65535));
            dr = 1'($urandom % 2);
            send(xr, dr, y);
            model_step(int'(xr), dr, e);
            check("random_model", y, e);
        end

        // Random backpressure and gaps on the input side.
        do_reset();
        k   = 0;
        cyc = 0;
        while (k < 64 && cyc < 2000) begin
            @(negedge aclk);
            s_tdata       = 16'h8000;
            dither_enable = 1'b0;
            s_tvalid      = ($urandom % 4) != 0;
            m_tready      = 1'($urandom % 2);
            #1;
            pv    = m_tvalid;
            pd    = m_tdata;
            pr    = s_tready;
            stall = pv && !m_tready;
            took  = s_tvalid && pr;
            check("bp_s_tready_rule", int'(pr), int'(!stall));
            @(posedge aclk);
            #1;
            if (took) begin
                check("bp_accept_vld", int'(m_tvalid), 1);
                check("bp_accept_y", int'($signed(m_tdata)), pat(k));
                k++;
            end else if (stall) begin
                check("bp_stall_dat", int'(m_tdata), int'(pd));
                check("bp_stall_vld", int'(m_tvalid), 1);
            end else begin
                check("bp_drain_vld", int'(m_tvalid), 0);
                check("bp_hold_dat", int'(m_tdata), int'(pd));
            end
            cyc++;
        end
        check("bp_samples_done", k, 64);

        // Reset pulse mid-stream.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(16'h8000, 1'b0, y);
            check("pre_rst_pattern", y, pat(i));
        end
        @(negedge aclk);
        rst = 1'b1;
        #1;
        check("mid_rst_m_tvalid", int'(m_tvalid), 0);
        check("mid_rst_s_tready", int'(s_tready), 0);
        @(posedge aclk);
        @(negedge aclk);
        rst = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("mid_rst_release_ready", int'(s_tready), 1);
        for (int i = 0; i < 8; i++) begin
            send(16'h8000, 1'b0, y);
            check("post_rst_pattern", y, pat(i));
        end

        // Long run: carries of stage 1 total exactly x over 2^16 samples.
        do_reset();
        sum     = 0;
        bad_rng = 0;
        bad_mdl = 0;
        for (int i = 0; i < 65536; i++) begin
            send(16'h1234, 1'b0, y);
            model_step(32'h1234, 1'b0, e);
            sum += y;
            if (y < MASH_Y_MIN || y > MASH_Y_MAX) bad_rng++;
            if (y != e) bad_mdl++;
        end
        check("long_range_violations", bad_rng, 0);
        check("long_model_mismatches", bad_mdl, 0);
        check("long_sum", sum, 4660 + mc2d);

        s_tvalid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mash_11_modulator.md
# mash_11_modulator

MASH 1-1 delta-sigma modulator stage for the DAC datapath. It consumes unsigned offset-binary samples from the NCO (`tx_i_data`/`tx_q_data` format), accepting them over an AXI-Stream-style handshake. It produces the signed multi-level MASH output (values −1..+2) that feeds the 1-bit DSM/upconverter stage. One instance is used per I/Q rail.

## Interface
- `WIDTH`, 16: input sample width; also the accumulator width of both stages.
- `MASH_BW`, 4: output width, signed two's complement. Must be ≥ 3.
- `LFSR_SEED`, 16'hACE1: dither LFSR reset value. Must be nonzero.

- `aclk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_tdata`  in  WIDTH  unsigned input sample x, fractional value x/2^WIDTH.
- `s_tvalid`  in  1  input valid.
- `s_tready`  out  1  input ready.
- `dither_enable`  in  1  when high, adds the LFSR LSB to the stage-1 carry-in.
- `m_tdata`  out  MASH_BW  signed modulator output y.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  downstream ready.

## Operation
- A sample is accepted on a cycle with `s_tvalid && s_tready`. All state advances only on acceptance.
- The following updates apply per accepted sample n. All sums are WIDTH+1 bits; the MSB is the carry.
  - Stage 1: `{c1, acc1} <= acc1 + x + d`, where d = `dither_enable ? lfsr[0] : 0`.
  - Stage 2: `{c2, acc2} <= acc2 + acc1_new`, where acc1_new is the stage-1 sum result from the same cycle.
  - Output: y = c1 + c2 − c2_d, sign-extended to MASH_BW. c2_d holds c2 of sample n−1 and is updated to c2 after use.
  - y ∈ {−1, 0, 1, 2}. Nothing saturates; accumulators wrap modulo 2^WIDTH.
- LFSR:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances on every accepted sample, regardless of `dither_enable`. This keeps the sequence deterministic w.r.t. sample index.
- Handshake (single output register):
  - `s_tready = !rst && (!m_tvalid || m_tready)`.
  - On acceptance: `m_tdata <= y`, `m_tvalid <= 1`.
  - Transfer without a new acceptance: `m_tvalid <= 0`. `m_tdata` holds its last value.
  - While `m_tvalid && !m_tready`, `m_tdata` is stable and no state changes.
  - Simultaneous output transfer and input acceptance: the new y is loaded and `m_tvalid` stays 1. This sustains full throughput of one sample per cycle.
- Reset values: acc1 = acc2 = 0, c2_d = 0, lfsr = LFSR_SEED, `m_tdata` = 0, `m_tvalid` = 0. `s_tready` is 0 while `rst` is high.
- Reset asserted mid-stream discards any pending output. After release, the modulator restarts from sample 0 with the states above.

## Timing
- Latency: y for a sample accepted at edge k is visible on `m_tdata`/`m_tvalid` after edge k. It is transferable at edge k+1 if `m_tready` = 1.
- Throughput: 1 sample/cycle with `m_tready` held high; `s_tready` stays 1.
- First cycle after reset deassertion: `s_tready` = 1 and `m_tvalid` = 0.
- There is no combinational path from `s_tdata` to `m_tdata`. `s_tready` depends combinationally on `m_tready`.

## Structure
- Package `mash_pkg` holds:
  - `MASH_Y_MIN` = −1 and `MASH_Y_MAX` = 2.
  - `LFSR_TAPS` = 16'hB400 and the default seed.
  - A `lfsr16_next()` function.
- Sub-module `mash_acc_stage`: WIDTH-bit accumulator with carry-in, enable, and outputs {carry, sum}. It is instantiated twice; stage 2 is tied to carry-in 0.
- `mash_11_modulator` instantiates both stages and holds c2_d, the LFSR, the output combiner, and the output register/handshake.

## Test plan
- x = 0, dither off, `m_tready` = 1, 64 samples: every y = 0.
- x = 16'h8000, dither off, from reset: y sequence 0, 1, 1, 0 repeating for 64 samples.
- x = 16'h1234, dither off, 65536 consecutive samples from reset: Σy = 0x1234 + c2 of the final sample, i.e. 4660 or 4661. All y ∈ {−1..2}.
- Backpressure test, x = 16'h8000, with `m_tready` toggled by a random 50% pattern:
  - `m_tdata` is stable while stalled.
  - `s_tready` = 0 exactly when `m_tvalid && !m_tready`.
  - The accepted-sample y sequence is still 0, 1, 1, 0.
- Dither on, x = 0: y stays in {−1..2}, and the sequence matches a reference model seeded with 16'hACE1. With the same stimulus and dither off, all y = 0.
- Assert `rst` for 1 cycle after 10 samples at x = 16'h8000:
  - `m_tvalid` drops immediately (asynchronous).
  - After release, the output sequence restarts at 0, 1, 1, 0.
